// File: rtl/fork_join_sched.sv
// rtl/fork_join_sched.sv - fork/join task launcher with per-slot delay counters
// Forks up to NUM_TASKS countdown tasks and reports join and wait-all events.
module fork_join_sched #(
  parameter int NUM_TASKS = 4,
  parameter int DLY_W     = 8,
  parameter int ID_W      = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [NUM_TASKS-1:0]       en_mask,
  input  logic [NUM_TASKS*DLY_W-1:0] delay_i,
  input  logic                       abort,
  output logic                       busy,
  output logic [NUM_TASKS-1:0]       active,
  output logic [NUM_TASKS-1:0]       task_done,
  output logic                       join_done,
  output logic                       all_done,
  output logic [ID_W-1:0]            done_id
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] MODE_ANY  = 2'd1;
  localparam logic [1:0] MODE_NONE = 2'd2;

  state_t               state;
  logic [1:0]           mode_q;
  logic                 joined;
  logic                 first_q;
  logic                 empty_q;
  logic [DLY_W-1:0]     cnt [NUM_TASKS];
  logic [NUM_TASKS-1:0] done_vec;
  logic [NUM_TASKS-1:0] next_active;
  logic [ID_W-1:0]      low_id;
  logic                 last_done;

  function automatic logic [ID_W-1:0] lowest(input logic [NUM_TASKS-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = NUM_TASKS - 1; i >= 0; i--) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  always_comb begin
    done_vec = '0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      done_vec[i] = active[i] && (cnt[i] == '0);
    end
    next_active = active & ~done_vec;
    low_id      = lowest(done_vec);
    last_done   = (done_vec != '0) && (next_active == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= '0;
      joined    <= 1'b0;
      first_q   <= 1'b0;
      empty_q   <= 1'b0;
      busy      <= 1'b0;
      active    <= '0;
      task_done <= '0;
      join_done <= 1'b0;
      all_done  <= 1'b0;
      done_id   <= '0;
      for (int i = 0; i < NUM_TASKS; i++) cnt[i] <= '0;
    end else begin
      task_done <= '0;
      join_done <= 1'b0;
      all_done  <= 1'b0;
      empty_q   <= 1'b0;

      // An empty fork never enters RUN; its events surface one edge later.
      if (empty_q) begin
        join_done <= 1'b1;
        all_done  <= 1'b1;
        done_id   <= '0;
      end

      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (en_mask == '0) begin
              empty_q <= 1'b1;
            end else begin
              state   <= RUN;
              busy    <= 1'b1;
              mode_q  <= mode;
              active  <= en_mask;
              joined  <= 1'b0;
              first_q <= 1'b1;
              for (int i = 0; i < NUM_TASKS; i++) begin
                cnt[i] <= en_mask[i] ? delay_i[i*DLY_W +: DLY_W] : '0;
              end
            end
          end
        end

        RUN: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            active <= '0;
            for (int i = 0; i < NUM_TASKS; i++) cnt[i] <= '0;
          end else begin
            first_q   <= 1'b0;
            active    <= next_active;
            task_done <= done_vec;
            for (int i = 0; i < NUM_TASKS; i++) begin
              if (active[i] && cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
            end

            if (mode_q == MODE_ANY) begin
              if (!joined && done_vec != '0) begin
                join_done <= 1'b1;
                done_id   <= low_id;
                joined    <= 1'b1;
              end
            end else if (mode_q == MODE_NONE) begin
              if (first_q) begin
                join_done <= 1'b1;
                done_id   <= '0;
              end
            end else if (last_done) begin
              join_done <= 1'b1;
              done_id   <= low_id;
            end

            if (last_done) begin
              all_done <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fork_join_sched.md
Name: fork_join_sched

Overview:
- Hardware task launcher and join barrier for the process-synchronisation work.
- One start pulse forks up to NUM_TASKS parallel delay "tasks". Each task counts down its own programmed delay, then reports completion.
- Reports the join point selected by mode (join all / join_any / join_none) and a separate wait-all barrier. Upstream sequencers stall on these events.

Parameters:
- NUM_TASKS, 4, number of parallel task slots (1..16)
- DLY_W, 8, width of each task delay field in cycles
- ID_W, $clog2(NUM_TASKS) (min 1), width of done_id

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  fork request, sampled only in IDLE
- mode  in  2  join mode, latched at start: 0=JOIN (all), 1=JOIN_ANY, 2=JOIN_NONE, 3=reserved (treated as JOIN)
- en_mask  in  NUM_TASKS  task enables, latched at start
- delay_i  in  NUM_TASKS*DLY_W  per-task delays, slot i at bits [i*DLY_W +: DLY_W], latched at start
- abort  in  1  synchronous kill of all running tasks
- busy  out  1  high while in RUN
- active  out  NUM_TASKS  per-task running flags
- task_done  out  NUM_TASKS  one-cycle completion pulse per task
- join_done  out  1  one-cycle pulse when the join condition of the latched mode is met
- all_done  out  1  one-cycle pulse when every enabled task has completed (wait-fork barrier)
- done_id  out  ID_W  task index associated with the last join_done

Behaviour:
- Reset: state=IDLE; busy, active, task_done, join_done, all_done, done_id, counters and latched mode/mask all 0.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states:
  - IDLE
  - RUN
- IDLE -> RUN:
  - Triggered when start=1 and abort=0 at edge E0.
  - At E0: latch mode; active<=en_mask; load cnt[i]<=delay[i] for enabled slots.
  - busy=1 from E0.
- Empty fork (en_mask=0 at start):
  - Stay in IDLE.
  - At E1, pulse join_done and all_done together, with done_id=0.
- RUN, per task i each edge:
  - If active[i] and cnt[i]!=0: decrement cnt[i].
  - If active[i] and cnt[i]==0: clear active[i] and pulse task_done[i].
  - Delay d therefore completes at edge E0+d+1. Delay 0 completes at E1. Maximum delay is 2^DLY_W-1.
- Join condition (join_done pulses in the same cycle as the triggering task_done):
  - JOIN: on the task_done that leaves active==0. done_id = lowest index among the pulses in that cycle.
  - JOIN_ANY: on the first cycle with any task_done. done_id = lowest index pulsing in that cycle. Later completions do not re-pulse.
  - JOIN_NONE: at E1 unconditionally (forked tasks keep running). done_id=0.
- join_done fires exactly once per fork.
- done_id holds its value until the next join_done.
- all_done:
  - Pulses on the cycle active becomes 0, as a registered event coincident with the final task_done.
  - FSM returns to IDLE on the same edge, so busy=0 from that edge.
- In JOIN mode, join_done and all_done pulse in the same cycle.
- Simultaneous completions: all corresponding task_done bits pulse together. For done_id, the lowest index wins.
- start while in RUN: ignored. Inputs are not re-latched.
- start on the same edge that returns the FSM to IDLE: ignored. A new fork needs start with busy=0.
- abort=1 at any edge (effective in RUN):
  - Clear active and counters; state -> IDLE.
  - No task_done, join_done or all_done pulse on that edge.
  - done_id is unchanged.
- abort together with start in IDLE: abort wins, no fork occurs.
- rst mid-RUN: immediate return to reset values. No pulses are emitted.

Test Plan:
- JOIN_ANY, en_mask=0111, delays {30, 12, 10} (task0, task1, task2): task_done[2] at E11 with join_done=1 and done_id=2. task_done[1] at E13. task_done[0] at E31 with all_done=1. busy=0 after E31.
- JOIN, en_mask=1111, delays {5, 5, 1, 9}: task_done[2] at E2; task_done[0] and task_done[1] together at E6; at E10, task_done[3], join_done and all_done all pulse together with done_id=3.
- JOIN_NONE, en_mask=0011, delays {0, 4}: join_done and task_done[0] at E1 with done_id=0. task_done[1] and all_done at E5.
- Tie and boundary: JOIN_ANY, en_mask=1010, delays {x, 3, x, 3}: task_done=1010 at E4, join_done with done_id=1. Then en_mask=0 start: join_done and all_done at E1 while busy stays 0.
- abort at E3 of a JOIN fork with delays all 8: active=0 and busy=0 after E3. No done pulses at any time. A start pulse 5 cycles later with busy=0 runs normally. A start pulse asserted while busy=1 is ignored.
- rst asserted asynchronously mid-RUN: all outputs 0 immediately. After release, a JOIN fork with delay 0 completes at E1.
